// File: rtl/osd_bitmap_tx.sv
// OSD bitmap frame streamer: header, WORDS payload words from memory,
// optional checksum trailer (enabled by macro OSD_TX_CSUM_EN), then a gap.
module osd_bitmap_tx #(
    parameter int          WORDS      = 256,
    parameter int          ADDR_W     = 11,
    parameter int          GAP_CYCLES = 16,
    parameter logic [15:0] MAGIC      = 16'h4F53
) (
    input  logic              udp_clk,
    input  logic              rstn,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [31:0]       tx_data,
    output logic              tx_sof,
    output logic              tx_last,
    output logic [15:0]       tx_len,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

`ifdef OSD_TX_CSUM_EN
    typedef enum logic [2:0] {
        IDLE, HDR, DATA, TRL, GAP
    } state_t;
    localparam logic [15:0] LEN = 16'(WORDS + 2);
`else
    typedef enum logic [2:0] {
        IDLE, HDR, DATA, GAP
    } state_t;
    localparam logic [15:0] LEN = 16'(WORDS + 1);
`endif

    localparam int DEPTH = 4;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] buf_q [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        rd_pend;
    logic [15:0] rd_idx;
    logic [15:0] tx_idx;
    logic [7:0]  gap_cnt;
    logic        fire;
    logic        pop;
    logic        push;
    logic        last_pay;
    logic        gap_done;
    logic        final_hs;
    logic        accept;
`ifdef OSD_TX_CSUM_EN
    logic [31:0] csum_q;
`endif

    assign fire     = tx_valid & tx_ready;
    assign pop      = (state_q == DATA) & fire;
    assign push     = rd_pend;
    assign last_pay = (tx_idx == 16'(WORDS - 1));
    assign accept   = (state_q == IDLE) & start;
    assign busy     = (state_q != IDLE);
    assign gap_done = (GAP_CYCLES <= 1) ||
                      (gap_cnt == 8'(GAP_CYCLES - 1));

    // Issue only when the slot (count + read in flight) is free; no tx_ready term.
    assign mem_rd_en = ((state_q == HDR) || (state_q == DATA)) &&
                       (rd_idx < 16'(WORDS)) &&
                       ((4'(count) + 4'(rd_pend)) < 4'(DEPTH));
    assign mem_rd_addr = ADDR_W'(rd_idx);

`ifdef OSD_TX_CSUM_EN
    assign final_hs = (state_q == TRL) & fire;
`else
    assign final_hs = pop & last_pay;
`endif

    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = 32'h0;
        tx_sof   = 1'b0;
        tx_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = HDR;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = {MAGIC, frame_cnt};
                tx_sof   = 1'b1;
                if (fire)
                    state_d = DATA;
            end
            DATA: begin
                tx_valid = (count != 3'd0);
                tx_data  = buf_q[rd_ptr];
`ifdef OSD_TX_CSUM_EN
                if (pop && last_pay)
                    state_d = TRL;
`else
                tx_last  = last_pay;
                if (pop && last_pay)
                    state_d = GAP;
`endif
            end
`ifdef OSD_TX_CSUM_EN
            TRL: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                tx_last  = 1'b1;
                if (fire)
                    state_d = GAP;
            end
`endif
            GAP: begin
                if (gap_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge udp_clk) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge udp_clk) begin
        if (push)
            buf_q[wr_ptr] <= mem_rd_data;
    end

    always_ff @(posedge udp_clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_pend   <= 1'b0;
            rd_idx    <= '0;
            tx_idx    <= '0;
            gap_cnt   <= '0;
            tx_len    <= '0;
            frame_cnt <= '0;
        end else begin
            rd_pend <= mem_rd_en;
            if (mem_rd_en)
                rd_idx <= rd_idx + 16'd1;
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
                tx_idx <= tx_idx + 16'd1;
            end
            count <= count + 3'(push) - 3'(pop);
            if (state_q == GAP)
                gap_cnt <= gap_cnt + 8'd1;
            else
                gap_cnt <= '0;
            if (final_hs)
                frame_cnt <= frame_cnt + 16'd1;
            if (accept) begin
                rd_idx <= '0;
                tx_idx <= '0;
                tx_len <= LEN;
            end
        end
    end

`ifdef OSD_TX_CSUM_EN
    always_ff @(posedge udp_clk) begin
        if (!rstn)
            csum_q <= '0;
        else if (accept)
            csum_q <= '0;
        else if (pop)
            csum_q <= csum_q + tx_data;
    end
`endif

endmodule

// File: tb/tb_osd_bitmap_tx.sv
// Scoreboard bench for osd_bitmap_tx: directed frames, backpressure,
// start-while-busy, reset mid-frame and a second payload pattern.
module tb_osd_bitmap_tx;

    localparam int WORDS = 256;
`ifdef OSD_TX_CSUM_EN
    localparam logic [15:0] EXP_LEN = 16'd258;
`else
    localparam logic [15:0] EXP_LEN = 16'd257;
`endif

    typedef struct {
        logic [31:0] d;
        logic        sof;
        logic        last;
    } exp_t;

    logic        udp_clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        mem_rd_en;
    logic [10:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_sof;
    logic        tx_last;
    logic [15:0] tx_len;
    logic        busy;
    logic [15:0] frame_cnt;

    logic [31:0] mem [WORDS];
    exp_t        sb [$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          hs_words = 0;
    int          hdr_cnt = 0;
    int          last_cnt = 0;
    int          last_cyc = 0;
    logic        bp = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 udp_clk = ~udp_clk;

    osd_bitmap_tx #(
        .WORDS(WORDS),
        .ADDR_W(11),
        .GAP_CYCLES(16),
        .MAGIC(16'h4F53)
    ) dut (
        .udp_clk(udp_clk),
        .rstn(rstn),
        .start(start),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_sof(tx_sof),
        .tx_last(tx_last),
        .tx_len(tx_len),
        .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always @(posedge udp_clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en)
            mem_rd_data <= mem[mem_rd_addr[7:0]];
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chk1(string n, logic a, logic e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic timeout(string n);
        checks++;
        fails++;
        $display("FAIL %s: got timeout expected event", n);
    endtask

    // Monitor: compares every handshake against the scoreboard.
    initial begin
        exp_t        e;
        logic        prev_stall;
        logic [31:0] prev_d;
        logic        prev_sof;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_sof = 1'b0;
        prev_last = 1'b0;
        forever begin
            @(negedge udp_clk);
            if (rstn !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk1("stall_valid", tx_valid, 1'b1);
                    chk("stall_data", tx_data, prev_d);
                    chk1("stall_sof", tx_sof, prev_sof);
                    chk1("stall_last", tx_last, prev_last);
                end
                if (mem_rd_en) begin
                    chk1("rd_range", mem_rd_addr < 11'(WORDS), 1'b1);
                    chk1("rd_busy", busy, 1'b1);
                end
                if (tx_valid && tx_ready) begin
                    if (sb.size() == 0) begin
                        timeout("unexpected_word");
                    end else begin
                        e = sb.pop_front();
                        chk("word", tx_data, e.d);
                        chk1("sof", tx_sof, e.sof);
                        chk1("last", tx_last, e.last);
                    end
                    if (tx_sof) begin
                        hdr_cnt++;
                        hs_words = 0;
                    end
                    hs_words++;
                    if (tx_last) begin
                        last_cnt++;
                        last_cyc = cyc;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_d = tx_data;
                prev_sof = tx_sof;
                prev_last = tx_last;
            end
        end
    end

    initial begin
        forever begin
            @(posedge udp_clk);
            #1;
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_frame();
        logic [31:0] sum;
        sum = '0;
        sb.push_back('{{16'h4F53, exp_cnt}, 1'b1, 1'b0});
        for (int i = 0; i < WORDS; i++) begin
`ifdef OSD_TX_CSUM_EN
            sb.push_back('{mem[i], 1'b0, 1'b0});
`else
            sb.push_back('{mem[i], 1'b0, i == WORDS - 1});
`endif
            sum = sum + mem[i];
        end
`ifdef OSD_TX_CSUM_EN
        sb.push_back('{sum, 1'b0, 1'b1});
`endif
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic pulse_start(output int c0);
        @(posedge udp_clk);
        #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge udp_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n;
        n = 0;
        do begin
            @(negedge udp_clk);
            n++;
        end while ((busy || sb.size() != 0) && n < budget);
        if (n >= budget)
            timeout("frame_done");
    endtask

    task automatic wait_hs(int h0, int nw);
        int n;
        n = 0;
        while (!(hdr_cnt > h0 && hs_words >= nw) && n < 3000) begin
            @(posedge udp_clk);
            #1;
            n++;
        end
        if (n >= 3000)
            timeout("wait_words");
    endtask

    task automatic wait_last(int l0);
        int n;
        n = 0;
        while (last_cnt <= l0 && n < 3000) begin
            @(negedge udp_clk);
            n++;
        end
        if (n >= 3000)
            timeout("wait_last");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int h0;
        int l0;
        int dly;
        rstn = 1'b0;
        start = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < WORDS; i++)
            mem[i] = 32'(i);
        repeat (3) @(posedge udp_clk);
        @(negedge udp_clk);
        chk1("rst_valid", tx_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_data", tx_data, 32'h0);
        chk("rst_len", 32'(tx_len), 32'h0);
        chk("rst_cnt", 32'(frame_cnt), 32'h0);
        @(posedge udp_clk);
        #1;
        rstn = 1'b1;

        // basic frame with full throughput
        push_frame();
        l0 = last_cnt;
        pulse_start(c0);
        wait_last(l0);
        dly = last_cyc - c0;
        chk1("throughput", dly >= 257 && dly <= 259, 1'b1);
        repeat (3) @(negedge udp_clk);
        chk1("gap_valid", tx_valid, 1'b0);
        chk1("gap_busy", busy, 1'b1);
        wait_done(1000);
        chk("cnt_basic", 32'(frame_cnt), 32'd1);
        chk("len_basic", 32'(tx_len), 32'(EXP_LEN));
        chk("hdr_basic", 32'(hdr_cnt), 32'd1);

        // backpressure
        bp = 1'b1;
        push_frame();
        pulse_start(c0);
        wait_done(5000);
        bp = 1'b0;
        chk("cnt_bp", 32'(frame_cnt), 32'd2);

        // start during DATA and GAP is ignored
        h0 = hdr_cnt;
        l0 = last_cnt;
        push_frame();
        pulse_start(c0);
        wait_hs(h0, 50);
        pulse_start(c0);
        wait_last(l0);
        repeat (3) @(negedge udp_clk);
        pulse_start(c0);
        c0 = 0;
        while (busy && c0 < 100) begin
            @(negedge udp_clk);
            c0++;
        end
        if (c0 >= 100)
            timeout("gap_end");
        push_frame();
        pulse_start(c0);
        wait_done(1000);
        chk("hdr_busy", 32'(hdr_cnt - h0), 32'd2);
        chk("cnt_busy", 32'(frame_cnt), 32'd4);

        // reset in the middle of payload
        h0 = hdr_cnt;
        push_frame();
        pulse_start(c0);
        wait_hs(h0, 102);
        rstn = 1'b0;
        @(posedge udp_clk);
        #1;
        rstn = 1'b1;
        sb.delete();
        exp_cnt = 16'd0;
        @(negedge udp_clk);
        chk1("abort_valid", tx_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk("abort_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge udp_clk);
        chk1("abort_quiet", tx_valid, 1'b0);
        push_frame();
        pulse_start(c0);
        wait_done(1000);
        chk("cnt_after_rst", 32'(frame_cnt), 32'd1);

        // second payload pattern (all-ones under checksum build)
`ifdef OSD_TX_CSUM_EN
        for (int i = 0; i < WORDS; i++)
            mem[i] = 32'hFFFFFFFF;
        sb.push_back('{{16'h4F53, exp_cnt}, 1'b1, 1'b0});
        for (int i = 0; i < WORDS; i++)
            sb.push_back('{32'hFFFFFFFF, 1'b0, 1'b0});
        sb.push_back('{32'hFFFFFF00, 1'b0, 1'b1});
        exp_cnt = exp_cnt + 16'd1;
`else
        for (int i = 0; i < WORDS; i++)
            mem[i] = 32'h01010101 * 32'(i) ^ 32'hA5A50000;
        push_frame();
`endif
        pulse_start(c0);
        wait_done(1000);
        chk("len_final", 32'(tx_len), 32'(EXP_LEN));
        chk("cnt_final", 32'(frame_cnt), 32'd2);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/osd_bitmap_tx.md
OSD_BITMAP_TX -- requirements
Module: osd_bitmap_tx

Interface
REQ-001 SHALL have parameter WORDS, default 256: payload words per frame (32 rows x 8 words of 32 bits); legal range 1..65534.
REQ-002 SHALL have parameter ADDR_W, default 11: width of mem_rd_addr.
REQ-003 SHALL have parameter GAP_CYCLES, default 16: idle cycles enforced after each frame; legal range 0..255.
REQ-004 SHALL have parameter MAGIC, default 16'h4F53: upper half of the header word.
REQ-005 SHALL have port udp_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to send one frame.
REQ-008 SHALL have port mem_rd_en, output, 1 bit: bitmap memory read strobe.
REQ-009 SHALL have port mem_rd_addr, output, ADDR_W bits: bitmap word address.
REQ-010 SHALL have port mem_rd_data, input, 32 bits: read data, valid exactly 1 cycle after the mem_rd_en cycle.
REQ-011 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-012 SHALL have port tx_ready, input, 1 bit: the UDP stack accepts the word.
REQ-013 SHALL have port tx_data, output, 32 bits: stream word.
REQ-014 SHALL have port tx_sof, output, 1 bit: marks the header word.
REQ-015 SHALL have port tx_last, output, 1 bit: marks the final word of the frame.
REQ-016 SHALL have port tx_len, output, 16 bits: total words in the current frame, including the header.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port frame_cnt, output, 16 bits: number of completed frames.

Function
REQ-019 SHALL implement the FSM states IDLE, HDR, DATA, TRL, GAP with these transitions:
- IDLE->HDR on start.
- HDR->DATA on header handshake.
- DATA->TRL, or DATA->GAP when the trailer is excluded, on the handshake of the last payload word.
- TRL->GAP on the trailer handshake.
- GAP->IDLE after GAP_CYCLES cycles; when GAP_CYCLES=0, GAP->IDLE occurs on the next cycle.
REQ-020 SHALL ignore start whenever busy=1; starts are not queued.
REQ-021 SHALL define a handshake as a cycle with tx_valid=1 and tx_ready=1.
REQ-022 SHALL hold tx_data, tx_sof and tx_last stable while tx_valid=1 and tx_ready=0.
REQ-023 SHALL make the header word {MAGIC, frame_cnt}, with tx_sof=1; tx_valid SHALL rise the cycle after start is accepted.
REQ-024 SHALL send payload word i equal to the memory contents at address i, in order i = 0..WORDS-1.
REQ-025 SHALL place a read-ahead buffer of at least 2 entries between memory and stream:
- mem_rd_en asserts only when a free entry is guaranteed.
- tx_ready has no combinational path to mem_rd_en or mem_rd_addr.
REQ-026 SHALL sustain 1 word/cycle in DATA when tx_ready is held high; first-payload bubble ≤2 cycles.
REQ-027 SHALL never read beyond address WORDS-1 and SHALL issue no reads outside HDR and DATA.
REQ-028 SHALL assert tx_last on the final word of the frame only.
REQ-029 SHALL latch tx_len when start is accepted.
REQ-030 SHALL increment frame_cnt by 1, modulo 2^16 with 16'hFFFF wrapping to 16'h0000, on the final handshake of a frame.
REQ-031 SHALL keep tx_valid low in IDLE and GAP.

Reset
REQ-032 SHALL, while rstn=0 at a clock edge, set the state to IDLE and force tx_valid, tx_sof, tx_last, mem_rd_en, busy, mem_rd_addr, tx_data, tx_len and frame_cnt to 0 and empty the buffer.
REQ-033 SHALL, when reset occurs mid-frame, abort the frame: no further words are sent, frame_cnt is not incremented, and outputs take their reset values on the next edge.
REQ-034 SHALL not accept start on the cycle rstn is low.

Configuration
REQ-035 SHALL, when macro OSD_TX_CSUM_EN is defined:
- append one trailer word after the payload, equal to the 32-bit wrap-around sum of all payload words;
- carry tx_last on the trailer;
- set tx_len = WORDS+2.
REQ-036 SHALL, when OSD_TX_CSUM_EN is undefined:
- omit the TRL state and the adder;
- carry tx_last on payload word WORDS-1;
- set tx_len = WORDS+1.

Verification
REQ-037 SHALL pass the basic-frame test: WORDS=256, memory[i]=i, tx_ready=1, start pulse -> header 32'h4F530000 with sof, then 256 words 0..255 back-to-back, last on word 255 (csum off), frame_cnt=1.
REQ-038 SHALL pass the backpressure test: tx_ready random ~50% -> identical word sequence, no drops or duplicates, data stable while stalled, reads stay ≤255.
REQ-039 SHALL pass the start-while-busy test: start pulsed during DATA and GAP -> ignored, exactly one frame sent; start right after GAP ends -> second header 32'h4F530001.
REQ-040 SHALL pass the checksum test: OSD_TX_CSUM_EN defined, memory[i]=32'hFFFFFFFF for all i -> trailer 32'hFFFFFF00, tx_len=258, last on trailer.
REQ-041 SHALL pass the reset-mid-frame test: rstn low for 1 cycle at payload word 100 -> tx_valid=0 next cycle, frame_cnt=0, a subsequent start produces a full frame from header.
REQ-042 SHALL pass the wrap test: 65536 frames sent -> frame_cnt wraps to 0, header field follows.
